// File: rtl/udma_hyper_cfg_pkg.sv
// Shared register offsets, per-device bank layout and commit FSM states for
// the uDMA HyperBus configuration register file.
package udma_hyper_cfg_pkg;

    localparam logic [4:0] OFS_PAGE_BOUND = 5'h00;
    localparam logic [4:0] OFS_T_LAT      = 5'h01;
    localparam logic [4:0] OFS_EN_LAT_ADD = 5'h02;
    localparam logic [4:0] OFS_T_CS_MAX   = 5'h03;
    localparam logic [4:0] OFS_T_RW_REC   = 5'h04;
    localparam logic [4:0] OFS_RWDS_DELAY = 5'h05;
    localparam logic [4:0] OFS_VARI_LAT   = 5'h06;
    localparam logic [4:0] OFS_MEM_SEL    = 5'h08;
    localparam logic [4:0] OFS_COMMIT     = 5'h10;
    localparam logic [4:0] OFS_ID_ALLOC   = 5'h11;
    localparam logic [4:0] OFS_ID_RELEASE = 5'h12;
    localparam logic [4:0] OFS_STATUS     = 5'h13;

    typedef struct packed {
        logic [2:0]  page_bound;
        logic [4:0]  t_lat;
        logic        en_lat_add;
        logic [31:0] t_cs_max;
        logic [31:0] t_rw_rec;
        logic [2:0]  rwds_delay;
        logic [3:0]  vari_lat;
        logic [1:0]  mem_sel;
    } hyper_dev_cfg_t;

    localparam hyper_dev_cfg_t HYPER_DEV_CFG_RST = '{
        page_bound: 3'd0,
        t_lat:      5'd6,
        en_lat_add: 1'b1,
        t_cs_max:   32'd665,
        t_rw_rec:   32'd6,
        rwds_delay: 3'd2,
        vari_lat:   4'd3,
        mem_sel:    2'd0
    };

    typedef enum logic [1:0] {IDLE, WAIT_IDLE, APPLY} commit_state_e;

endpackage

// File: rtl/udma_hyper_id_alloc.sv
// Reserve-on-read channel ID allocator: lowest free ID search plus reservation tracking.
// Optional reservation timeout enabled by UDMA_HYPER_CFG_ALLOC_TIMEOUT_EN.
module udma_hyper_id_alloc #(
    parameter int unsigned NB_CH         = 4,
    parameter int unsigned ALLOC_TIMEOUT = 1024
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [NB_CH-1:0] busy_vec_i,
    input  logic             alloc_req_i,
    input  logic             release_req_i,
    input  logic [31:0]      release_id_i,
    input  logic             status_rd_i,
    output logic             alloc_valid_o,
    output logic [3:0]       alloc_id_o,
    output logic [NB_CH-1:0] reserved_o,
    output logic             timeout_flag_o
);

    logic [NB_CH-1:0] reserved_q, reserved_d;
    logic [NB_CH-1:0] free_vec, grant, expire;

    // Search uses the live busy vector so a channel going busy this cycle is skipped.
    always_comb begin
        free_vec      = ~busy_vec_i & ~reserved_q;
        alloc_valid_o = |free_vec;
        alloc_id_o    = '0;
        grant         = '0;
        for (int i = NB_CH - 1; i >= 0; i--) begin
            if (free_vec[i]) alloc_id_o = 4'(i);
        end
        for (int i = 0; i < NB_CH; i++) begin
            grant[i] = alloc_req_i && alloc_valid_o && (alloc_id_o == 4'(i));
        end
    end

    always_comb begin
        reserved_d = reserved_q | grant;
        for (int i = 0; i < NB_CH; i++) begin
            if (busy_vec_i[i] || expire[i] || (release_req_i && release_id_i == 32'(i))) begin
                reserved_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) reserved_q <= '0;
        else         reserved_q <= reserved_d;
    end

    assign reserved_o = reserved_q;

`ifdef UDMA_HYPER_CFG_ALLOC_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(ALLOC_TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q [NB_CH];
    logic [CNT_W-1:0] cnt_d [NB_CH];
    logic             tflag_q, tflag_d;

    // Counter holds ALLOC_TIMEOUT after the allocating edge; expiry on the edge it hits 0.
    always_comb begin
        for (int i = 0; i < NB_CH; i++) begin
            cnt_d[i]  = cnt_q[i];
            expire[i] = reserved_q[i] && (cnt_q[i] <= CNT_W'(1));
            if (reserved_q[i] && cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CNT_W'(1);
            if (grant[i]) cnt_d[i] = CNT_W'(ALLOC_TIMEOUT);
        end
        tflag_d = status_rd_i ? 1'b0 : tflag_q;
        if (|expire) tflag_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tflag_q <= 1'b0;
            for (int i = 0; i < NB_CH; i++) cnt_q[i] <= '0;
        end else begin
            tflag_q <= tflag_d;
            cnt_q   <= cnt_d;
        end
    end

    assign timeout_flag_o = tflag_q;
`else
    localparam int unsigned unused_timeout = ALLOC_TIMEOUT;
    logic unused_status_rd;

    assign unused_status_rd = status_rd_i;
    assign expire           = '0;
    assign timeout_flag_o   = 1'b0;
`endif

endmodule

// File: rtl/udma_hyper_cfg_regs.sv
// HyperBus multi-device config register file: shadow/active banks, idle-gated commit FSM
// and channel ID allocator. Reservation timeout enabled by UDMA_HYPER_CFG_ALLOC_TIMEOUT_EN.
module udma_hyper_cfg_regs
    import udma_hyper_cfg_pkg::*;
#(
    parameter int unsigned NB_DEV          = 2,
    parameter int unsigned NB_CH           = 4,
    parameter int unsigned DELAY_BIT_WIDTH = 3,
    parameter int unsigned CFG_AW          = 8,
    parameter int unsigned ALLOC_TIMEOUT   = 1024
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [31:0]                       cfg_data_i,
    input  logic [CFG_AW-1:0]                 cfg_addr_i,
    input  logic                              cfg_valid_i,
    input  logic                              cfg_reg_rwn_i,
    output logic [31:0]                       cfg_data_o,
    output logic                              cfg_ready_o,
    output logic [NB_DEV*5-1:0]               cfg_t_latency_access_o,
    output logic [NB_DEV-1:0]                 cfg_en_latency_additional_o,
    output logic [NB_DEV*32-1:0]              cfg_t_cs_max_o,
    output logic [NB_DEV*32-1:0]              cfg_t_read_write_recovery_o,
    output logic [NB_DEV*DELAY_BIT_WIDTH-1:0] cfg_t_rwds_delay_line_o,
    output logic [NB_DEV*4-1:0]               cfg_t_variable_latency_check_o,
    output logic [NB_DEV*3-1:0]               cfg_page_bound_o,
    output logic [NB_DEV*2-1:0]               cfg_mem_sel_o,
    output logic                              cfg_update_o,
    input  logic [NB_CH-1:0]                  busy_vec_i
);

    localparam int unsigned DLY_W    = (DELAY_BIT_WIDTH < 3) ? DELAY_BIT_WIDTH : 3;
    localparam logic [2:0]  DLY_MASK = 3'((1 << DLY_W) - 1);

    hyper_dev_cfg_t shadow_q [NB_DEV];
    hyper_dev_cfg_t shadow_d [NB_DEV];
    hyper_dev_cfg_t active_q [NB_DEV];
    hyper_dev_cfg_t active_v [NB_DEV];
    hyper_dev_cfg_t dev_rd;
    commit_state_e  state_q, state_d;
    logic           pending_q, pending_d;

    logic [4:0]        cfg_off;
    logic [CFG_AW-6:0] dev_idx;
    logic              wr_en, rd_en;
    logic              alloc_valid, timeout_flag;
    logic [3:0]        alloc_id;
    logic [NB_CH-1:0]  reserved;
    logic [31:0]       status;

    assign cfg_off     = cfg_addr_i[4:0];
    assign dev_idx     = cfg_addr_i[CFG_AW-1:5];
    assign cfg_ready_o = (state_q != APPLY);
    assign wr_en       = cfg_valid_i && cfg_ready_o && !cfg_reg_rwn_i;
    assign rd_en       = cfg_valid_i && cfg_ready_o && cfg_reg_rwn_i;

    udma_hyper_id_alloc #(
        .NB_CH         (NB_CH),
        .ALLOC_TIMEOUT (ALLOC_TIMEOUT)
    ) u_id_alloc (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .busy_vec_i     (busy_vec_i),
        .alloc_req_i    (rd_en && cfg_off == OFS_ID_ALLOC),
        .release_req_i  (wr_en && cfg_off == OFS_ID_RELEASE),
        .release_id_i   (cfg_data_i),
        .status_rd_i    (rd_en && cfg_off == OFS_STATUS),
        .alloc_valid_o  (alloc_valid),
        .alloc_id_o     (alloc_id),
        .reserved_o     (reserved),
        .timeout_flag_o (timeout_flag)
    );

    always_comb begin
        shadow_d = shadow_q;
        for (int d = 0; d < NB_DEV; d++) begin
            if (wr_en && 32'(dev_idx) == 32'(d)) begin
                case (cfg_off)
                    OFS_PAGE_BOUND: shadow_d[d].page_bound = cfg_data_i[2:0];
                    OFS_T_LAT:      shadow_d[d].t_lat      = cfg_data_i[4:0];
                    OFS_EN_LAT_ADD: shadow_d[d].en_lat_add = cfg_data_i[0];
                    OFS_T_CS_MAX:   shadow_d[d].t_cs_max   = cfg_data_i;
                    OFS_T_RW_REC:   shadow_d[d].t_rw_rec   = cfg_data_i;
                    OFS_RWDS_DELAY: shadow_d[d].rwds_delay = cfg_data_i[2:0] & DLY_MASK;
                    OFS_VARI_LAT:   shadow_d[d].vari_lat   = cfg_data_i[3:0];
                    OFS_MEM_SEL:    shadow_d[d].mem_sel    = cfg_data_i[1:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        dev_rd = '0;
        for (int d = 0; d < NB_DEV; d++) begin
            if (32'(dev_idx) == 32'(d)) dev_rd = shadow_q[d];
        end
        status              = '0;
        status[0]           = pending_q;
        status[1]           = (state_q == APPLY);
        status[8 +: NB_CH]  = reserved;
        status[31]          = timeout_flag;

        cfg_data_o = '0;
        if (rd_en) begin
            case (cfg_off)
                OFS_PAGE_BOUND: cfg_data_o = 32'(dev_rd.page_bound);
                OFS_T_LAT:      cfg_data_o = 32'(dev_rd.t_lat);
                OFS_EN_LAT_ADD: cfg_data_o = 32'(dev_rd.en_lat_add);
                OFS_T_CS_MAX:   cfg_data_o = dev_rd.t_cs_max;
                OFS_T_RW_REC:   cfg_data_o = dev_rd.t_rw_rec;
                OFS_RWDS_DELAY: cfg_data_o = 32'(dev_rd.rwds_delay & DLY_MASK);
                OFS_VARI_LAT:   cfg_data_o = 32'(dev_rd.vari_lat);
                OFS_MEM_SEL:    cfg_data_o = 32'(dev_rd.mem_sel);
                OFS_ID_ALLOC:   cfg_data_o = alloc_valid ? {1'b1, 27'b0, alloc_id} : '0;
                OFS_STATUS:     cfg_data_o = status;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        if (wr_en && cfg_off == OFS_COMMIT) pending_d = 1'b1;
        unique case (state_q)
            IDLE:      if (pending_q) state_d = WAIT_IDLE;
            WAIT_IDLE: if ((busy_vec_i | reserved) == '0) state_d = APPLY;
            APPLY: begin
                state_d   = IDLE;
                pending_d = 1'b0;
            end
            default:   state_d = IDLE;
        endcase
    end

    // Shadow is frozen during APPLY (ready low), so it is shown on the outputs that cycle.
    always_comb begin
        for (int d = 0; d < NB_DEV; d++) begin
            active_v[d] = (state_q == APPLY) ? shadow_q[d] : active_q[d];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            for (int d = 0; d < NB_DEV; d++) begin
                shadow_q[d] <= HYPER_DEV_CFG_RST;
                active_q[d] <= HYPER_DEV_CFG_RST;
            end
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
            if (state_q == APPLY) active_q <= shadow_q;
        end
    end

    assign cfg_update_o = (state_q == APPLY);

    for (genvar d = 0; d < NB_DEV; d++) begin : g_out
        assign cfg_t_latency_access_o[d*5 +: 5]          = active_v[d].t_lat;
        assign cfg_en_latency_additional_o[d]            = active_v[d].en_lat_add;
        assign cfg_t_cs_max_o[d*32 +: 32]                = active_v[d].t_cs_max;
        assign cfg_t_read_write_recovery_o[d*32 +: 32]   = active_v[d].t_rw_rec;
        assign cfg_t_rwds_delay_line_o[d*DELAY_BIT_WIDTH +: DELAY_BIT_WIDTH] =
            DELAY_BIT_WIDTH'(active_v[d].rwds_delay & DLY_MASK);
        assign cfg_t_variable_latency_check_o[d*4 +: 4]  = active_v[d].vari_lat;
        assign cfg_page_bound_o[d*3 +: 3]                = active_v[d].page_bound;
        assign cfg_mem_sel_o[d*2 +: 2]                   = active_v[d].mem_sel;
    end

endmodule
